corner_stabilizer: RTL

- Sits directly downstream of the per-frame corner finder in the camera/VGA path.
- Consumes its once-per-frame valid pulse, success flag and four corner addresses.
- Produces temporally smoothed, lock-tracked corner addresses for the warp/overlay stages.
- Single-frame detection failures are bridged by holding the last good corners; large corner jumps are followed immediately.

---
 rtl/corner_stabilizer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/corner_stabilizer.sv
`default_nettype none
// ============================================================================
//  Module   : corner_stabilizer
//  Purpose  : Temporal smoothing and lock tracking of the four per-frame
//             corner addresses produced by the corner finder. Small moves are
//             filtered with a shift-based IIR step, large moves snap, and
//             short runs of failed detections are bridged by holding.
//  Revision : 1.0  initial release
// ============================================================================
module corner_stabilizer #(
  parameter int SHIFT       = 2,
  parameter int JUMP_TH     = 64,
  parameter int HOLD_FRAMES = 8,
  parameter int MAX_ROW     = 599,
  parameter int MAX_COL     = 799
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_success,
  input  logic [19:0] i_ul_addr,
  input  logic [19:0] i_ur_addr,
  input  logic [19:0] i_dl_addr,
  input  logic [19:0] i_dr_addr,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_busy,
  output logic [19:0] o_ul_addr,
  output logic [19:0] o_ur_addr,
  output logic [19:0] o_dl_addr,
  output logic [19:0] o_dr_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC0 = 3'd1,
    S_CALC1 = 3'd2,
    S_CALC2 = 3'd3,
    S_CALC3 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] in_q  [4];
  logic [19:0] out_q [4];
  logic        succ_q;
  logic        locked_q;
  logic [7:0]  miss_q;
  logic        valid_q;

  logic        w_capture;
  logic        w_calc;
  logic        w_busy;
  logic [1:0]  w_idx;

  // Corner index 0..3 = ul, ur, dl, dr; bit1 selects bottom row, bit0 right col.
  function automatic logic [19:0] default_corner(input logic [1:0] idx);
    logic [9:0] r;
    logic [9:0] c;
    r = idx[1] ? 10'(MAX_ROW) : 10'd0;
    c = idx[0] ? 10'(MAX_COL) : 10'd0;
    return {r, c};
  endfunction

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and per-state controls; CALCn selects corner n.
  always_comb begin
    state_d   = state_q;
    w_capture = 1'b0;
    w_calc    = 1'b0;
    w_busy    = 1'b0;
    w_idx     = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          w_capture = 1'b1;
          state_d   = S_CALC0;
        end
      end
      S_CALC0: begin w_calc = 1'b1; w_busy = 1'b1; w_idx = 2'd0; state_d = S_CALC1; end
      S_CALC1: begin w_calc = 1'b1; w_busy = 1'b1; w_idx = 2'd1; state_d = S_CALC2; end
      S_CALC2: begin w_calc = 1'b1; w_busy = 1'b1; w_idx = 2'd2; state_d = S_CALC3; end
      S_CALC3: begin w_calc = 1'b1; w_busy = 1'b1; w_idx = 2'd3; state_d = S_DONE;  end
      S_DONE:  begin w_busy = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared per-corner arithmetic unit.
  // ---------------------------------------------------------------------------
  logic [19:0]        w_in, w_out, w_new;
  logic signed [10:0] w_drow, w_dcol;
  logic [10:0]        w_arow, w_acol;
  logic [11:0]        w_dist;
  logic [9:0]         w_mrow, w_mcol;
  logic [9:0]         w_step_row, w_step_col;
  logic               w_drop;

  assign w_in  = in_q[w_idx];
  assign w_out = out_q[w_idx];

  // locked_q only changes on the CALC3->DONE edge, so every CALC cycle of a
  // frame sees the same mode that was present at CALC0.
  assign w_drop = locked_q && !succ_q && (miss_q == 8'(HOLD_FRAMES - 1));

  // Signed deltas, Manhattan distance and the minimum-one IIR step per axis.
  always_comb begin
    w_drow = $signed({1'b0, w_in[19:10]}) - $signed({1'b0, w_out[19:10]});
    w_dcol = $signed({1'b0, w_in[9:0]})   - $signed({1'b0, w_out[9:0]});
    w_arow = w_drow[10] ? 11'(-w_drow) : 11'(w_drow);
    w_acol = w_dcol[10] ? 11'(-w_dcol) : 11'(w_dcol);
    w_dist = {1'b0, w_arow} + {1'b0, w_acol};

    // Magnitudes never exceed 1023, so 10 bits hold the shifted step.
    w_mrow = 10'(w_arow >> SHIFT);
    w_mcol = 10'(w_acol >> SHIFT);
    if (w_mrow == 10'd0 && w_arow != 11'd0) w_mrow = 10'd1;
    if (w_mcol == 10'd0 && w_acol != 11'd0) w_mcol = 10'd1;

    // Step never overshoots the input, so no wrap or clamp is possible.
    w_step_row = w_drow[10] ? (w_out[19:10] - w_mrow) : (w_out[19:10] + w_mrow);
    w_step_col = w_dcol[10] ? (w_out[9:0]   - w_mcol) : (w_out[9:0]   + w_mcol);

    if (succ_q) begin
      if (!locked_q || (w_dist > 12'(JUMP_TH))) w_new = w_in;
      else                                      w_new = {w_step_row, w_step_col};
    end else if (locked_q && !w_drop) begin
      w_new = w_out;
    end else begin
      w_new = default_corner(w_idx);
    end
  end

  // Input snapshot taken on an accepted i_valid pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) in_q[i] <= 20'd0;
      succ_q <= 1'b0;
    end else if (w_capture) begin
      in_q[0] <= i_ul_addr;
      in_q[1] <= i_ur_addr;
      in_q[2] <= i_dl_addr;
      in_q[3] <= i_dr_addr;
      succ_q  <= i_success;
    end
  end

  // Output corner registers, one written per CALC cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) out_q[i] <= default_corner(2'(i));
    end else if (w_calc) begin
      out_q[w_idx] <= w_new;
    end
  end

  // Lock flag and miss counter, committed as the frame enters DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      locked_q <= 1'b0;
      miss_q   <= 8'd0;
    end else if (state_q == S_CALC3) begin
      if (succ_q) begin
        locked_q <= 1'b1;
        miss_q   <= 8'd0;
      end else if (locked_q) begin
        if (w_drop) begin
          locked_q <= 1'b0;
          miss_q   <= 8'd0;
        end else begin
          miss_q <= miss_q + 8'd1;
        end
      end
    end
  end

  // One-cycle completion pulse following DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) valid_q <= 1'b0;
    else          valid_q <= (state_q == S_DONE);
  end

  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_busy    = w_busy;
  assign o_ul_addr = out_q[0];
  assign o_ur_addr = out_q[1];
  assign o_dl_addr = out_q[2];
  assign o_dr_addr = out_q[3];

endmodule
`default_nettype wire
